// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 receive path.
// Frame layout: start(0), eight data bits LSB first, odd parity, stop(1).
package ps2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    PARITY,
    STOP
  } state_t;

  localparam int FRAME_DATA_BITS        = 8;
  localparam int DEFAULT_FILTER_LEN     = 8;
  localparam int DEFAULT_TIMEOUT_CYCLES = 100000;

  // A frame is good when data plus parity hold an odd number of ones and stop is high.
  function automatic logic frame_ok(input logic [FRAME_DATA_BITS-1:0] data,
                                    input logic parity,
                                    input logic stop);
    return (^{data, parity}) & stop;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// Two-flop synchroniser plus run-length glitch filter for one PS/2 line.
// Emits the filtered level and a one-cycle pulse on each filtered 1->0 transition.
module ps2_line_filter
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN = DEFAULT_FILTER_LEN
) (
  input  logic clk,
  input  logic rst,
  input  logic line,
  output logic level,
  output logic fall
);

  localparam logic [7:0] LAST = 8'(FILTER_LEN - 1);

  logic [1:0] sync;
  logic [7:0] cnt;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values; blocking here would collapse the synchroniser into one stage.
  // The synchroniser and level reset to 1 so an idle-high line produces no edge
  // when reset is released.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync  <= 2'b11;
      level <= 1'b1;
      cnt   <= '0;
      fall  <= 1'b0;
    end else begin
      sync <= {sync[0], line};
      fall <= 1'b0;
      if (sync[1] == level) begin
        cnt <= '0;
      end else if (cnt == LAST) begin
        level <= sync[1];
        cnt   <= '0;
        fall  <= level;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end
  end

endmodule

// File: rtl/ps2_receiver.sv
// PS/2 device-to-host receiver: filters the PS/2 clock, decodes 11-bit frames
// and presents each good byte with a one-cycle strobe for the keyboard matrix.
module ps2_receiver
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = DEFAULT_FILTER_LEN,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] ps2_data,
  output logic       ps2_data_clk,
  output logic       ps2_err,
  output logic       busy
);

  localparam int TO_W  = $clog2(TIMEOUT_CYCLES + 1);
  localparam int CNT_W = $clog2(FRAME_DATA_BITS);
  localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(FRAME_DATA_BITS - 1);

  logic                       clk_level;
  logic                       clk_fall;
  logic                       sample;
  logic [1:0]                 dat_sync;
  logic                       dat;
  state_t                     state;
  logic [CNT_W-1:0]           bit_cnt;
  logic [FRAME_DATA_BITS-1:0] shift;
  logic                       par;
  logic [TO_W-1:0]            to_cnt;

  ps2_line_filter #(
    .FILTER_LEN (FILTER_LEN)
  ) u_clk_filter (
    .clk   (CLOCK_50),
    .rst   (reset),
    .line  (ps2_clk),
    .level (clk_level),
    .fall  (clk_fall)
  );

  // The fall pulse always coincides with the freshly lowered filtered level.
  assign sample = clk_fall & ~clk_level;
  assign dat    = dat_sync[1];

  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      dat_sync <= 2'b11;
    end else begin
      dat_sync <= {dat_sync[0], ps2_dat};
    end
  end

  // NOTE: both strobes get a default of 0 at the top of the clocked block, so
  // each branch only states when a pulse fires and none can stick high.
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      bit_cnt      <= '0;
      shift        <= '0;
      par          <= 1'b0;
      to_cnt       <= '0;
      ps2_data     <= 8'h00;
      ps2_data_clk <= 1'b0;
      ps2_err      <= 1'b0;
      busy         <= 1'b0;
    end else begin
      ps2_data_clk <= 1'b0;
      ps2_err      <= 1'b0;
      if (sample) begin
        to_cnt <= '0;
        case (state)
          IDLE: begin
            if (!dat) begin
              state   <= DATA;
              busy    <= 1'b1;
              bit_cnt <= '0;
            end
          end
          DATA: begin
            shift[bit_cnt] <= dat;
            if (bit_cnt == BIT_LAST) begin
              state <= PARITY;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
          PARITY: begin
            par   <= dat;
            state <= STOP;
          end
          STOP: begin
            state <= IDLE;
            busy  <= 1'b0;
            if (frame_ok(shift, par, dat)) begin
              ps2_data     <= shift;
              ps2_data_clk <= 1'b1;
            end else begin
              ps2_err <= 1'b1;
            end
          end
          default: begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        endcase
      end else if (state == IDLE) begin
        to_cnt <= '0;
      end else if (to_cnt == TO_LAST) begin
        // Device went quiet mid-frame: drop the partial frame and flag it.
        to_cnt  <= '0;
        state   <= IDLE;
        busy    <= 1'b0;
        ps2_err <= 1'b1;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end
    end
  end

endmodule
